// File: rtl/score_keeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | score_keeper - N-channel 2-digit BCD scoreboard, win detect, winner blink  |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module score_keeper #(
  parameter int N_CH      = 2,
  parameter int WIN_SCORE = 21,
  parameter int WRAP      = 0,
  parameter int BLINK_CYC = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   inc,
  input  logic [N_CH-1:0]   dec,
  input  logic              clr,
  output logic [8*N_CH-1:0] score_bcd,
  output logic [N_CH-1:0]   digit_blank,
  output logic              win,
  output logic [1:0]        winner
);

  localparam int               CNT_W     = $clog2(BLINK_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_CYC - 1);
  localparam logic [3:0]       WIN_TENS  = 4'(WIN_SCORE / 10);
  localparam logic [3:0]       WIN_UNITS = 4'(WIN_SCORE % 10);
  localparam logic             WRAP_EN   = (WRAP != 0);

  if (N_CH < 1 || N_CH > 4 || WIN_SCORE < 1 || WIN_SCORE > 99 || BLINK_CYC < 2) begin : g_bad_params
    $error("score_keeper: illegal parameter set");
  end

  typedef enum logic [0:0] {
    ST_PLAY = 1'b0,
    ST_WIN  = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] blink_cnt;
  logic             phase;
  logic [N_CH-1:0]  match;
  logic             any_match;
  logic [1:0]       match_idx;

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)        return WRAP_EN ? 8'h00 : 8'h99;
    if (s[3:0] == 4'd9)    return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] s);
    if (s == 8'h00)        return WRAP_EN ? 8'h99 : 8'h00;
    if (s[3:0] == 4'd0)    return {s[7:4] - 4'd1, 4'd9};
    return {s[7:4], s[3:0] - 4'd1};
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [7:0] score;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        score <= 8'h00;
      else if (clr)
        score <= 8'h00;
      else if (state == ST_PLAY && inc[i] && !dec[i])
        score <= bcd_inc(score);
      else if (state == ST_PLAY && dec[i] && !inc[i])
        score <= bcd_dec(score);
    end

    assign score_bcd[8*i +: 8] = score;
    assign match[i]            = (score == {WIN_TENS, WIN_UNITS});
    assign digit_blank[i]      = win && phase && (winner == 2'(i));
  end

  // Lowest matching channel wins a tie.
  always_comb begin
    any_match = 1'b0;
    match_idx = 2'b00;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (match[i]) begin
        any_match = 1'b1;
        match_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_PLAY;
      win       <= 1'b0;
      winner    <= 2'b00;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (clr) begin
      state     <= ST_PLAY;
      win       <= 1'b0;
      winner    <= 2'b00;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      case (state)
        ST_PLAY: begin
          if (any_match) begin
            state     <= ST_WIN;
            win       <= 1'b1;
            winner    <= match_idx;
            blink_cnt <= '0;
            phase     <= 1'b0;
          end
        end
        ST_WIN: begin
          if (blink_cnt == CNT_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
        default: state <= ST_PLAY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// tb_score_keeper - vector table, directed corner sequences and random play
// checked against an integer scoreboard model of three score_keeper variants.
module tb_score_keeper;

  localparam int BLINK = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] inc = 2'b00;
  logic [1:0] dec = 2'b00;
  logic       clr = 1'b0;

  logic [15:0] sc [3];
  logic [1:0]  bl [3];
  logic        wn [3];
  logic [1:0]  wi [3];

  // Variant 0: main (21, saturate); 1: saturate with win at 99; 2: wrap with win at 50.
  score_keeper #(.N_CH(2), .WIN_SCORE(21), .WRAP(0), .BLINK_CYC(BLINK)) dut_a (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .clr(clr),
    .score_bcd(sc[0]), .digit_blank(bl[0]), .win(wn[0]), .winner(wi[0]));
  score_keeper #(.N_CH(2), .WIN_SCORE(99), .WRAP(0), .BLINK_CYC(BLINK)) dut_s (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .clr(clr),
    .score_bcd(sc[1]), .digit_blank(bl[1]), .win(wn[1]), .winner(wi[1]));
  score_keeper #(.N_CH(2), .WIN_SCORE(50), .WRAP(1), .BLINK_CYC(BLINK)) dut_w (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .clr(clr),
    .score_bcd(sc[2]), .digit_blank(bl[2]), .win(wn[2]), .winner(wi[2]));

  always #5 clk = ~clk;

  // Reference model: plain integer scores, win flag, cycles spent in WIN.
  int p_win  [3] = '{21, 99, 50};
  bit p_wrap [3] = '{1'b0, 1'b0, 1'b1};
  int m_s    [3][2];
  bit m_win  [3];
  int m_who  [3];
  int m_wcyc [3];

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_s[k][0] = 0; m_s[k][1] = 0;
      m_win[k] = 1'b0; m_who[k] = 0; m_wcyc[k] = 0;
    end
  endfunction

  function automatic void model_step(input logic [1:0] i, input logic [1:0] d, input logic c);
    for (int k = 0; k < 3; k++) begin
      if (c) begin
        m_s[k][0] = 0; m_s[k][1] = 0;
        m_win[k] = 1'b0; m_who[k] = 0; m_wcyc[k] = 0;
      end else if (m_win[k]) begin
        m_wcyc[k]++;
      end else begin
        int w = -1;
        for (int ch = 1; ch >= 0; ch--)
          if (m_s[k][ch] == p_win[k]) w = ch;
        for (int ch = 0; ch < 2; ch++) begin
          if (i[ch] && !d[ch])
            m_s[k][ch] = (m_s[k][ch] == 99) ? (p_wrap[k] ? 0 : 99) : m_s[k][ch] + 1;
          else if (d[ch] && !i[ch])
            m_s[k][ch] = (m_s[k][ch] == 0) ? (p_wrap[k] ? 99 : 0) : m_s[k][ch] - 1;
        end
        if (w >= 0) begin
          m_win[k] = 1'b1; m_who[k] = w; m_wcyc[k] = 0;
        end
      end
    end
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [1:0] exp_blank(input int k);
    if (m_win[k] && ((m_wcyc[k] / BLINK) % 2 == 1)) return 2'(1 << m_who[k]);
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s dut%0d score", tag, k), 32'(sc[k]),
          32'({to_bcd(m_s[k][1]), to_bcd(m_s[k][0])}));
      chk($sformatf("%s dut%0d win", tag, k), 32'(wn[k]), 32'(m_win[k]));
      chk($sformatf("%s dut%0d winner", tag, k), 32'(wi[k]), m_win[k] ? 32'(m_who[k]) : 32'd0);
      chk($sformatf("%s dut%0d blank", tag, k), 32'(bl[k]), 32'(exp_blank(k)));
    end
  endtask

  task automatic step(input logic [1:0] i, input logic [1:0] d, input logic c, input string tag);
    inc = i; dec = d; clr = c;
    @(posedge clk);
    model_step(i, d, c);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    inc = 2'b00; dec = 2'b00; clr = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    chk({tag, " async score"}, 32'(sc[0]), 32'h0);
    chk({tag, " async win"}, 32'(wn[0]), 32'h0);
    chk({tag, " async blank"}, 32'(bl[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step(2'b00, 2'b00, 1'b0);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    logic [1:0]  inc;
    logic [1:0]  dec;
    logic        clr;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [8];
  logic [9:0] pat = 10'b0011110000;

  initial begin
    tbl[0] = '{2'b01, 2'b00, 1'b0, 16'h0001};
    tbl[1] = '{2'b11, 2'b00, 1'b0, 16'h0102};
    tbl[2] = '{2'b01, 2'b01, 1'b0, 16'h0102};
    tbl[3] = '{2'b00, 2'b10, 1'b0, 16'h0002};
    tbl[4] = '{2'b00, 2'b10, 1'b0, 16'h0002};
    tbl[5] = '{2'b00, 2'b01, 1'b0, 16'h0001};
    tbl[6] = '{2'b10, 2'b00, 1'b1, 16'h0000};
    tbl[7] = '{2'b01, 2'b10, 1'b0, 16'h0001};

    model_reset();
    #12;
    check_all("reset");
    chk("reset score", 32'(sc[0]), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    model_step(2'b00, 2'b00, 1'b0);
    #1;
    check_all("post_reset");

    // 13 pulses on ch0, 7 on ch1, overlapping in 4 cycles
    for (int c = 0; c < 16; c++)
      step({1'(c >= 9), 1'(c < 13)}, 2'b00, 1'b0, "count");
    chk("count 0713", 32'(sc[0]), 32'h0713);
    chk("count win", 32'(wn[0]), 32'h0);

    step(2'b00, 2'b00, 1'b1, "clr");
    for (int t = 0; t < 8; t++) begin
      step(tbl[t].inc, tbl[t].dec, tbl[t].clr, "table");
      chk($sformatf("table[%0d]", t), 32'(sc[0]), 32'(tbl[t].exp));
    end

    // Carry, borrow and saturation on the WIN_SCORE=99 variant
    step(2'b00, 2'b00, 1'b1, "clr");
    for (int c = 0; c < 9; c++) step(2'b01, 2'b00, 1'b0, "carry");
    chk("sat 09", 32'(sc[1][7:0]), 32'h09);
    step(2'b01, 2'b00, 1'b0, "carry");
    chk("sat 09+1", 32'(sc[1][7:0]), 32'h10);
    step(2'b00, 2'b01, 1'b0, "borrow");
    chk("sat 10-1", 32'(sc[1][7:0]), 32'h09);
    step(2'b00, 2'b00, 1'b1, "clr");
    step(2'b00, 2'b01, 1'b0, "floor");
    chk("sat 00-1", 32'(sc[1][7:0]), 32'h00);
    for (int c = 0; c < 99; c++) step(2'b01, 2'b00, 1'b0, "to99");
    chk("sat reach 99", 32'(sc[1][7:0]), 32'h99);
    chk("sat win not yet", 32'(wn[1]), 32'h0);
    step(2'b01, 2'b00, 1'b0, "ceil");
    chk("sat 99+1", 32'(sc[1][7:0]), 32'h99);
    chk("sat win at 99", 32'(wn[1]), 32'h1);

    // Wrap variant
    step(2'b00, 2'b00, 1'b1, "clr");
    step(2'b00, 2'b01, 1'b0, "wrap");
    chk("wrap 00-1", 32'(sc[2][7:0]), 32'h99);
    step(2'b01, 2'b00, 1'b0, "wrap");
    chk("wrap 99+1", 32'(sc[2][7:0]), 32'h00);

    // Simultaneous inc/dec, clr priority
    step(2'b00, 2'b00, 1'b1, "clr");
    for (int c = 0; c < 5; c++) step(2'b01, 2'b00, 1'b0, "to05");
    step(2'b01, 2'b01, 1'b0, "incdec");
    chk("inc+dec at 05", 32'(sc[0]), 32'h0005);
    step(2'b10, 2'b00, 1'b1, "clr_inc");
    chk("clr beats inc", 32'(sc[0]), 32'h0000);

    // Win on ch1, blink and clear
    for (int c = 0; c < 21; c++) step(2'b10, 2'b00, 1'b0, "to21");
    chk("win score 21", 32'(sc[0]), 32'h2100);
    chk("win latency t+1", 32'(wn[0]), 32'h0);
    step(2'b00, 2'b00, 1'b0, "win");
    chk("win latency t+2", 32'(wn[0]), 32'h1);
    chk("winner ch1", 32'(wi[0]), 32'h1);
    chk("blink k0", 32'(bl[0]), 32'h0);
    step(2'b11, 2'b00, 1'b0, "frozen");
    chk("frozen score", 32'(sc[0]), 32'h2100);
    chk("blink k1", 32'(bl[0]), 32'h0);
    for (int k = 2; k < 10; k++) begin
      step(2'b00, 2'b00, 1'b0, "blink");
      chk($sformatf("blink k%0d", k), 32'(bl[0]), pat[k] ? 32'h2 : 32'h0);
    end
    for (int k = 0; k < 3; k++) step(2'b00, 2'b00, 1'b0, "blink");
    chk("blink k12", 32'(bl[0]), 32'h2);
    step(2'b00, 2'b00, 1'b1, "clr_blink");
    chk("clr score", 32'(sc[0]), 32'h0);
    chk("clr win", 32'(wn[0]), 32'h0);
    chk("clr blank", 32'(bl[0]), 32'h0);

    // Tie: lowest index wins, then async reset mid-blink
    for (int c = 0; c < 20; c++) step(2'b11, 2'b00, 1'b0, "to20");
    step(2'b11, 2'b00, 1'b0, "tie");
    chk("tie score", 32'(sc[0]), 32'h2121);
    step(2'b00, 2'b00, 1'b0, "tie_win");
    chk("tie win", 32'(wn[0]), 32'h1);
    chk("tie winner", 32'(wi[0]), 32'h0);
    for (int k = 0; k < 5; k++) step(2'b00, 2'b00, 1'b0, "tie_blink");
    chk("tie blink", 32'(bl[0]), 32'h1);
    async_reset("areset");

    // Random play against the model
    step(2'b00, 2'b00, 1'b1, "clr");
    for (int n = 0; n < 2000; n++) begin
      logic [1:0] ri, rd;
      logic       rc;
      ri = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      rd = {1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0)};
      rc = 1'($urandom_range(0, 59) == 0);
      step(ri, rd, rc, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
